// File: rtl/fifo_pkg.sv
// Shared helpers for the gearbox FIFO: lane/unit arithmetic and parameter
// legality checks used at elaboration time.
package fifo_pkg;

  function automatic int unsigned min_w(input int unsigned a, input int unsigned b);
    return (a < b) ? a : b;
  endfunction

  function automatic int unsigned max_w(input int unsigned a, input int unsigned b);
    return (a > b) ? a : b;
  endfunction

  // Width ratio between the wide and narrow side (1 for symmetric FIFOs).
  function automatic int unsigned width_ratio(input int unsigned a, input int unsigned b);
    return max_w(a, b) / min_w(a, b);
  endfunction

  function automatic bit is_pow2(input int unsigned x);
    return (x != 0) && ((x & (x - 1)) == 0);
  endfunction

  // True when the width pair and depth form a legal configuration.
  function automatic bit params_ok(input int unsigned in_w, input int unsigned out_w,
                                   input int unsigned depth);
    int unsigned r;
    if (in_w == 0 || out_w == 0) return 1'b0;
    if ((max_w(in_w, out_w) % min_w(in_w, out_w)) != 0) return 1'b0;
    r = width_ratio(in_w, out_w);
    return is_pow2(r) && is_pow2(depth) && (depth >= 2 * r);
  endfunction

endpackage

// File: rtl/fifo_sync_mem.sv
// Flop-array storage of DEPTH narrow units with a multi-unit write port and a
// multi-unit combinational read port; both ports wrap modulo DEPTH.
//   clk   : write clock
//   we    : write enable, stores WR_UNITS units starting at waddr
//   waddr : first unit address of the write
//   wdata : write data, unit 0 in the low lanes
//   raddr : first unit address of the read
//   rdata : RD_UNITS units starting at raddr, unit 0 in the low lanes
module fifo_sync_mem #(
  parameter int unsigned N_W      = 8,
  parameter int unsigned DEPTH    = 16,
  parameter int unsigned WR_UNITS = 1,
  parameter int unsigned RD_UNITS = 1,
  parameter int unsigned AW       = $clog2(DEPTH)
) (
  input  logic                         clk,
  input  logic                         we,
  input  logic [AW-1:0]                waddr,
  input  logic [WR_UNITS*N_W-1:0]      wdata,
  input  logic [AW-1:0]                raddr,
  output logic [RD_UNITS*N_W-1:0]      rdata
);

  logic [N_W-1:0] mem [DEPTH];

  // Storage is intentionally not reset.
  always_ff @(posedge clk) begin
    if (we) begin
      for (int i = 0; i < int'(WR_UNITS); i++) begin
        mem[AW'(waddr + AW'(i))] <= wdata[i*N_W +: N_W];
      end
    end
  end

  // First-word fall-through read of RD_UNITS consecutive units.
  always_comb begin
    rdata = '0;
    for (int j = 0; j < int'(RD_UNITS); j++) begin
      rdata[j*N_W +: N_W] = mem[AW'(raddr + AW'(j))];
    end
  end

endmodule

// File: rtl/fifo_sync_gearbox.sv
// Single-clock FIFO with independent write/read widths (power-of-two ratio),
// occupancy count, programmable thresholds and synchronous flush.
//   clk, rst          : clock, asynchronous active-high reset
//   flush             : synchronous clear, wins over a concurrent handshake
//   in_valid/in_ready : write handshake, in_data IN_WIDTH bits
//   out_valid/out_ready: read handshake, out_data OUT_WIDTH bits (fall-through)
//   count             : occupancy in narrow units
//   prog_full/empty   : threshold flags against registered count
module fifo_sync_gearbox
  import fifo_pkg::*;
#(
  parameter int unsigned IN_WIDTH          = 8,
  parameter int unsigned OUT_WIDTH         = 8,
  parameter int unsigned DEPTH             = 16,
  parameter int unsigned PROG_FULL_THRESH  = 12,
  parameter int unsigned PROG_EMPTY_THRESH = 2
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         flush,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [IN_WIDTH-1:0]          in_data,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [OUT_WIDTH-1:0]         out_data,
  output logic [$clog2(DEPTH+1)-1:0]   count,
  output logic                         prog_full,
  output logic                         prog_empty
);

  localparam int unsigned N_W = min_w(IN_WIDTH, OUT_WIDTH);
  localparam int unsigned IW  = IN_WIDTH / N_W;
  localparam int unsigned OW  = OUT_WIDTH / N_W;
  localparam int unsigned AW  = $clog2(DEPTH);
  localparam int unsigned CW  = $clog2(DEPTH + 1);

  if (!params_ok(IN_WIDTH, OUT_WIDTH, DEPTH)) begin : g_bad_params
    $fatal(1, "fifo_sync_gearbox: illegal width ratio or DEPTH");
  end

  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [CW-1:0] count_next;
  logic          wr_fire;
  logic          rd_fire;

  // Handshake and flags depend only on registered count (plus rst for in_ready).
  always_comb begin
    in_ready   = ~rst & (32'(count) <= (DEPTH - IW));
    out_valid  = (32'(count) >= OW);
    prog_full  = (32'(count) >= PROG_FULL_THRESH);
    prog_empty = (32'(count) <= PROG_EMPTY_THRESH);
    wr_fire    = in_valid & in_ready;
    rd_fire    = out_valid & out_ready;
    count_next = count + (wr_fire ? CW'(IW) : '0) - (rd_fire ? CW'(OW) : '0);
  end

  // Pointer and occupancy state; flush discards the handshake of its cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (wr_fire) wr_ptr <= wr_ptr + AW'(IW);
      if (rd_fire) rd_ptr <= rd_ptr + AW'(OW);
      count <= count_next;
    end
  end

  fifo_sync_mem #(
    .N_W      (N_W),
    .DEPTH    (DEPTH),
    .WR_UNITS (IW),
    .RD_UNITS (OW),
    .AW       (AW)
  ) u_mem (
    .clk   (clk),
    .we    (wr_fire & ~flush),
    .waddr (wr_ptr),
    .wdata (in_data),
    .raddr (rd_ptr),
    .rdata (out_data)
  );

endmodule
